tqvp_pwm_multich: RTL and testbench

Multi-channel PWM peripheral for the TinyQV byte-peripheral slot, the successor to the single-channel PWM. It drives `NUM_CH` independent PWM outputs from one shared prescaled timebase with a programmable period (TOP), edge- or center-aligned counting, per-channel polarity and shadowed duty registers. Duty and TOP take effect only at period boundaries, so outputs never glitch. Software reads and writes it over the standard 4-bit-address byte register bus.

---
 rtl/pwm_pkg.sv | 29 ++
 rtl/pwm_channel.sv | 54 +++++
 rtl/tqvp_pwm_multich.sv | 181 ++++++++++++++++++
 tb/tb_tqvp_pwm_multich.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel TinyQV PWM peripheral:
// register addresses, CTRL/STATUS bit positions and a channel-count check.
package pwm_pkg;

   localparam int MAX_CH = 8;

   localparam logic [3:0] ADDR_CTRL      = 4'h0;
   localparam logic [3:0] ADDR_PRESC     = 4'h1;
   localparam logic [3:0] ADDR_TOP       = 4'h2;
   localparam logic [3:0] ADDR_POL       = 4'h3;
   localparam logic [3:0] ADDR_STATUS    = 4'h4;
   localparam logic [3:0] ADDR_DUTY_BASE = 4'h8;

   localparam int CTRL_EN_BIT     = 0;
   localparam int CTRL_CENTER_BIT = 1;
   localparam int STATUS_PEND_BIT = 0;
   localparam int STATUS_DIR_BIT  = 1;

   typedef struct packed {
      logic center;
      logic en;
   } ctrl_t;

   // Used by the top level to reject unsupported channel counts at elaboration.
   function automatic bit num_ch_ok(int num_ch);
      return (num_ch >= 1) && (num_ch <= MAX_CH);
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty pair, compare against the shared
// counter, polarity inversion and a registered output pin.
module pwm_channel (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       we,
   input  logic [7:0] data,
   input  logic [7:0] counter,
   input  logic [7:0] top,
   input  logic       pol,
   input  logic       en,
   output logic [7:0] duty_shadow,
   output logic       pwm
);

   logic [7:0] duty_shadow_q, duty_shadow_d;
   logic [7:0] duty_q, duty_d;
   logic       pwm_q, pwm_d;
   logic       raw;

   always_comb begin
      duty_shadow_d = we ? data : duty_shadow_q;
      // The shadow's current value moves to active, so a write landing on
      // the load cycle waits for the following period end.
      duty_d = load ? duty_shadow_q : duty_q;

      if (duty_q == 8'd0) begin
         raw = 1'b0;
      end else if ((duty_q == 8'hFF) || (duty_q > top)) begin
         raw = 1'b1;
      end else begin
         raw = (counter < duty_q);
      end

      pwm_d = en ? (raw ^ pol) : pol;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         duty_shadow_q <= 8'd0;
         duty_q        <= 8'd0;
         pwm_q         <= 1'b0;
      end else begin
         duty_shadow_q <= duty_shadow_d;
         duty_q        <= duty_d;
         pwm_q         <= pwm_d;
      end
   end

   assign duty_shadow = duty_shadow_q;
   assign pwm         = pwm_q;

endmodule

// File: rtl/tqvp_pwm_multich.sv
// Multi-channel PWM for the TinyQV byte-peripheral slot: register decode,
// shared prescaler, edge/center counter, active TOP and sticky PEND flag.
module tqvp_pwm_multich
   import pwm_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int PRESC_W = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [3:0] address,
   input  logic       data_write,
   input  logic [7:0] data_in,
   output logic [7:0] data_out
);

   if (!num_ch_ok(NUM_CH) || (PRESC_W < 1) || (PRESC_W > 8)) begin : g_param_check
      $error("tqvp_pwm_multich: NUM_CH and PRESC_W must both be in 1..8");
   end

   localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

   ctrl_t              ctrl_q, ctrl_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
   logic [7:0]         top_shadow_q, top_shadow_d;
   logic [7:0]         top_q, top_d;
   logic [7:0]         counter_q, counter_d;
   logic [NUM_CH-1:0]  pol_q, pol_d;
   logic               dir_q, dir_d;
   logic               pend_q, pend_d;

   logic               tick;
   logic               period_end;
   logic               load;
   logic               status_clr;
   logic [NUM_CH-1:0]  duty_we;
   logic [NUM_CH-1:0]  pwm;
   logic [7:0]         duty_shadow [NUM_CH];
   logic               unused_ui;

   assign unused_ui = ^ui_in;

   // NOTE: every always_comb output gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      ctrl_d       = ctrl_q;
      presc_d      = presc_q;
      top_shadow_d = top_shadow_q;
      pol_d        = pol_q;
      if (data_write) begin
         case (address)
            ADDR_CTRL:  ctrl_d       = '{center: data_in[CTRL_CENTER_BIT],
                                         en:     data_in[CTRL_EN_BIT]};
            ADDR_PRESC: presc_d      = data_in[PRESC_W-1:0];
            ADDR_TOP:   top_shadow_d = data_in;
            ADDR_POL:   pol_d        = data_in[NUM_CH-1:0];
            default:    ;
         endcase
      end
   end

   always_comb begin
      tick        = 1'b0;
      period_end  = 1'b0;
      presc_cnt_d = '0;
      counter_d   = 8'd0;
      dir_d       = 1'b0;
      if (ctrl_q.en) begin
         tick        = (presc_cnt_q == presc_q);
         presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_ONE;
         counter_d   = counter_q;
         dir_d       = dir_q;
         if (tick) begin
            if (top_q == 8'd0) begin
               counter_d  = 8'd0;
               dir_d      = 1'b0;
               period_end = 1'b1;
            end else if (!ctrl_q.center) begin
               dir_d = 1'b0;
               if (counter_q == top_q) begin
                  counter_d  = 8'd0;
                  period_end = 1'b1;
               end else begin
                  counter_d = counter_q + 8'd1;
               end
            end else if (!dir_q) begin
               if (counter_q == top_q) begin
                  dir_d     = 1'b1;
                  counter_d = top_q - 8'd1;
               end else begin
                  counter_d = counter_q + 8'd1;
               end
            end else if (counter_q == 8'd0) begin
               // Bottom of the down slope; a new TOP of 0 must park at 0.
               dir_d      = 1'b0;
               counter_d  = (top_shadow_q == 8'd0) ? 8'd0 : 8'd1;
               period_end = 1'b1;
            end else begin
               counter_d = counter_q - 8'd1;
            end
         end
      end
   end

   assign load       = period_end || !ctrl_q.en;
   assign status_clr = data_write && (address == ADDR_STATUS) && data_in[STATUS_PEND_BIT];
   assign top_d      = load ? top_shadow_q : top_q;
   assign pend_d     = period_end || (pend_q && !status_clr);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q       <= '0;
         presc_q      <= '0;
         presc_cnt_q  <= '0;
         top_shadow_q <= 8'd0;
         top_q        <= 8'd0;
         counter_q    <= 8'd0;
         pol_q        <= '0;
         dir_q        <= 1'b0;
         pend_q       <= 1'b0;
      end else begin
         ctrl_q       <= ctrl_d;
         presc_q      <= presc_d;
         presc_cnt_q  <= presc_cnt_d;
         top_shadow_q <= top_shadow_d;
         top_q        <= top_d;
         counter_q    <= counter_d;
         pol_q        <= pol_d;
         dir_q        <= dir_d;
         pend_q       <= pend_d;
      end
   end

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      assign duty_we[n] = data_write && (address == (ADDR_DUTY_BASE + 4'(n)));

      pwm_channel u_ch (
         .clk         (clk),
         .rst         (rst),
         .load        (load),
         .we          (duty_we[n]),
         .data        (data_in),
         .counter     (counter_q),
         .top         (top_q),
         .pol         (pol_q[n]),
         .en          (ctrl_q.en),
         .duty_shadow (duty_shadow[n]),
         .pwm         (pwm[n])
      );
   end

   always_comb begin
      data_out = 8'h00;
      case (address)
         ADDR_CTRL: begin
            data_out[CTRL_EN_BIT]     = ctrl_q.en;
            data_out[CTRL_CENTER_BIT] = ctrl_q.center;
         end
         ADDR_PRESC: data_out = 8'(presc_q);
         ADDR_TOP:   data_out = top_shadow_q;
         ADDR_POL:   data_out = 8'(pol_q);
         ADDR_STATUS: begin
            data_out[STATUS_PEND_BIT] = pend_q;
            data_out[STATUS_DIR_BIT]  = dir_q;
         end
         default: begin
            for (int n = 0; n < NUM_CH; n++) begin
               if (address == (ADDR_DUTY_BASE + 4'(n))) data_out = duty_shadow[n];
            end
         end
      endcase
   end

   assign uo_out = 8'(pwm);

endmodule

// File: tb/tb_tqvp_pwm_multich.sv
// Directed bench for tqvp_pwm_multich: register access, edge/center
// waveforms, shadow timing, duty extremes, polarity, PEND race and reset.
module tb_tqvp_pwm_multich;
   import pwm_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [3:0] address;
   logic       data_write;
   logic [7:0] data_in;
   logic [7:0] data_out;

   int n_vec  = 0;
   int n_miss = 0;

   tqvp_pwm_multich #(.NUM_CH(4), .PRESC_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .ui_in      (ui_in),
      .uo_out     (uo_out),
      .address    (address),
      .data_write (data_write),
      .data_in    (data_in),
      .data_out   (data_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
      end
   endtask

   // Called on a falling edge; the write lands on the next rising edge and
   // the task returns on the falling edge after it.
   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      address    = a;
      data_in    = d;
      data_write = 1'b1;
      @(negedge clk);
      data_write = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
      address = a;
      #1;
      check(tag, data_out, exp);
   endtask

   // Expected pins for each falling edge after an enable (index k-1).
   logic [7:0] exp_edge   [8]  = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00};
   logic [7:0] exp_shadow [6]  = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00};
   logic [7:0] exp_top    [8]  = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01};
   logic [7:0] exp_center [20] = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00,
                                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02,
                                   8'h02, 8'h02, 8'h02, 8'h02};
   logic [7:0] exp_ext    [4]  = '{8'h0A, 8'h0A, 8'h02, 8'h02};

   initial begin
      rst        = 1'b1;
      ui_in      = 8'h00;
      address    = 4'h0;
      data_write = 1'b0;
      data_in    = 8'h00;

      // Reset and register map.
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_uo_out", uo_out, 8'h00);
      for (int a = 0; a < 16; a++) rd_check($sformatf("rst_reg[%0d]", a), 4'(a), 8'h00);
      repeat (5) @(negedge clk);
      check("idle_uo_out", uo_out, 8'h00);
      rd_check("idle_status", ADDR_STATUS, 8'h00);
      wr(4'h5, 8'hFF);
      rd_check("unmapped_5", 4'h5, 8'h00);
      wr(4'hC, 8'hA5);
      rd_check("absent_duty4", 4'hC, 8'h00);
      wr(ADDR_CTRL, 8'hFC);
      rd_check("ctrl_upper_bits", ADDR_CTRL, 8'h00);

      // Edge mode: TOP=3, DUTY0=2, PRESCALE=0.
      wr(ADDR_TOP, 8'd3);
      rd_check("top_rd", ADDR_TOP, 8'd3);
      wr(ADDR_DUTY_BASE, 8'd2);
      rd_check("duty0_rd", ADDR_DUTY_BASE, 8'd2);
      wr(ADDR_CTRL, 8'h01);
      rd_check("ctrl_rd", ADDR_CTRL, 8'h01);
      check("edge_first_pin", uo_out, 8'h00);
      address = ADDR_STATUS;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check($sformatf("edge_pin[%0d]", k), uo_out, exp_edge[k-1]);
         if (k == 3) check("edge_pend_before", data_out, 8'h00);
         if (k == 4) check("edge_pend_after", data_out, 8'h01);
      end

      // PEND clear, then clear on a period-end cycle (set must win).
      @(negedge clk);
      wr(ADDR_STATUS, 8'h01);
      rd_check("pend_clr", ADDR_STATUS, 8'h00);
      @(negedge clk);
      wr(ADDR_STATUS, 8'h01);
      rd_check("pend_set_wins", ADDR_STATUS, 8'h01);

      // Mid-period DUTY0 write 1 -> 3 is deferred to the next period.
      wr(ADDR_CTRL, 8'h00);
      wr(ADDR_DUTY_BASE, 8'd1);
      wr(ADDR_CTRL, 8'h01);
      check("shadow_first_pin", uo_out, 8'h00);
      @(negedge clk);
      check("shadow_pin[1]", uo_out, 8'h01);
      wr(ADDR_DUTY_BASE, 8'd3);
      check("shadow_pin[2]", uo_out, 8'h00);
      rd_check("shadow_duty_rd", ADDR_DUTY_BASE, 8'd3);
      for (int k = 3; k <= 8; k++) begin
         @(negedge clk);
         check($sformatf("shadow_pin[%0d]", k), uo_out, exp_shadow[k-3]);
      end

      // TOP write on the period-end cycle (counter 3) waits one period.
      repeat (3) @(negedge clk);
      wr(ADDR_TOP, 8'd1);
      rd_check("top_shadow_rd", ADDR_TOP, 8'd1);
      for (int k = 13; k <= 20; k++) begin
         @(negedge clk);
         check($sformatf("top_defer_pin[%0d]", k), uo_out, exp_top[k-13]);
      end

      // Center mode: PRESCALE=1, TOP=4, DUTY1=2, DUTY0=0.
      wr(ADDR_CTRL, 8'h00);
      wr(ADDR_PRESC, 8'd1);
      wr(ADDR_TOP, 8'd4);
      wr(ADDR_DUTY_BASE, 8'd0);
      wr(ADDR_DUTY_BASE + 4'd1, 8'd2);
      wr(ADDR_STATUS, 8'h01);
      rd_check("center_pend_clr", ADDR_STATUS, 8'h00);
      wr(ADDR_CTRL, 8'h03);
      rd_check("center_ctrl_rd", ADDR_CTRL, 8'h03);
      address = ADDR_STATUS;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         check($sformatf("center_pin[%0d]", k), uo_out, exp_center[k-1]);
         if (k == 9)  check("center_dir_up", data_out, 8'h00);
         if (k == 10) check("center_dir_down", data_out, 8'h02);
         if (k == 17) check("center_pre_end", data_out, 8'h02);
         if (k == 18) check("center_period_end", data_out, 8'h01);
      end

      // Duty extremes and polarity in edge mode, TOP=3.
      wr(ADDR_CTRL, 8'h00);
      wr(ADDR_PRESC, 8'd0);
      wr(ADDR_TOP, 8'd3);
      wr(ADDR_DUTY_BASE, 8'd255);
      wr(ADDR_DUTY_BASE + 4'd1, 8'd5);
      wr(ADDR_DUTY_BASE + 4'd3, 8'd2);
      wr(ADDR_POL, 8'hFF);
      rd_check("pol_rd_masked", ADDR_POL, 8'h0F);
      wr(ADDR_POL, 8'h01);
      @(negedge clk);
      check("idle_pol_level", uo_out, 8'h01);
      wr(ADDR_CTRL, 8'h01);
      check("ext_first_pin", uo_out, 8'h01);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check($sformatf("ext_pin[%0d]", k), uo_out, exp_ext[(k-1) % 4]);
      end

      // Disable mid-period (counter 1), then re-enable from counter 0.
      @(negedge clk);
      wr(ADDR_CTRL, 8'h00);
      check("dis_last_pin", uo_out, 8'h0A);
      @(negedge clk);
      check("dis_idle_pin", uo_out, 8'h01);
      @(negedge clk);
      check("dis_idle_hold", uo_out, 8'h01);
      wr(ADDR_CTRL, 8'h01);
      check("reen_first_pin", uo_out, 8'h01);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check($sformatf("reen_pin[%0d]", k), uo_out, exp_ext[k-1]);
      end

      // Reset pulse mid-run clears everything, shadows included.
      wr(ADDR_PRESC, 8'd2);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst2_uo_out", uo_out, 8'h00);
      rd_check("rst2_ctrl", ADDR_CTRL, 8'h00);
      rd_check("rst2_presc", ADDR_PRESC, 8'h00);
      rd_check("rst2_top", ADDR_TOP, 8'h00);
      rd_check("rst2_pol", ADDR_POL, 8'h00);
      rd_check("rst2_status", ADDR_STATUS, 8'h00);
      for (int n = 0; n < 4; n++) rd_check($sformatf("rst2_duty[%0d]", n), ADDR_DUTY_BASE + 4'(n), 8'h00);
      repeat (4) @(negedge clk);
      check("rst2_uo_hold", uo_out, 8'h00);
      rd_check("rst2_status_hold", ADDR_STATUS, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
